// File: rtl/fifo_drain_arb.sv
// rtl/fifo_drain_arb.sv - round-robin drain of CH FWFT FIFOs into a start/finish handshake sink
// Define FIFO_DRAIN_TIMEOUT_EN to abort a WAIT that outlives TIMEOUT_CYC enabled cycles (sets sticky err).
module fifo_drain_arb #(
  parameter int DATA_W      = 8,
  parameter int CH          = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [CH-1:0]          fifo_busy,
  input  logic [CH-1:0]          fifo_empty,
  input  logic [CH*DATA_W-1:0]   fifo_data,
  output logic [CH-1:0]          fifo_re,
  output logic [DATA_W-1:0]      out_data,
  output logic [$clog2(CH)-1:0]  out_chan,
  output logic                   out_start,
  input  logic                   out_finish,
  output logic                   isFinish,
  output logic [15:0]            xfer_cnt,
  output logic                   err
);
  localparam int CW = $clog2(CH);

  if (CH < 2 || CH > 16) begin : g_ch_range
    $error("fifo_drain_arb: CH must be 2..16");
  end
  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_timeout_range
    $error("fifo_drain_arb: TIMEOUT_CYC must be 2..65535");
  end

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t              state_q, state_d;
  logic [CH-1:0]       fifo_re_q, fifo_re_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [CW-1:0]       out_chan_q, out_chan_d;
  logic                out_start_q, out_start_d;
  logic                is_finish_q, is_finish_d;
  logic [15:0]         xfer_cnt_q, xfer_cnt_d;
  logic [CW-1:0]       last_grant_q, last_grant_d;
  logic                err_d;

  logic [CH-1:0]       ready;
  logic                grant_vld;
  logic [CW-1:0]       grant_idx;
  logic [CW-1:0]       cand;
  logic [DATA_W-1:0]   data_arr [CH];

  for (genvar i = 0; i < CH; i++) begin : g_unpack
    assign data_arr[i] = fifo_data[i*DATA_W +: DATA_W];
  end

  // Search starts one past the previous winner so every ready channel gets a turn.
  always_comb begin
    ready     = ~fifo_busy & ~fifo_empty;
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 1; k <= CH; k++) begin
      cand = CW'((int'(last_grant_q) + k) % CH);
      if (!grant_vld && ready[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

`ifdef FIFO_DRAIN_TIMEOUT_EN
  logic [15:0] to_cnt_q, to_cnt_d;
  logic        err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    fifo_re_d    = '0;
    out_data_d   = out_data_q;
    out_chan_d   = out_chan_q;
    out_start_d  = out_start_q;
    is_finish_d  = is_finish_q;
    xfer_cnt_d   = xfer_cnt_q;
    last_grant_d = last_grant_q;
`ifdef FIFO_DRAIN_TIMEOUT_EN
    to_cnt_d     = to_cnt_q;
    err_d        = err_q;
`else
    err_d        = 1'b0;
`endif
    if (enable) begin
      case (state_q)
        IDLE: begin
          if (grant_vld) begin
            fifo_re_d    = CH'(1) << grant_idx;
            out_data_d   = data_arr[grant_idx];
            out_chan_d   = grant_idx;
            last_grant_d = grant_idx;
            is_finish_d  = 1'b0;
            state_d      = START;
          end
        end
        START: begin
          out_start_d = 1'b1;
          state_d     = WAIT;
`ifdef FIFO_DRAIN_TIMEOUT_EN
          to_cnt_d    = '0;
`endif
        end
        WAIT: begin
          if (out_finish) begin
            out_start_d = 1'b0;
            state_d     = DONE;
          end
`ifdef FIFO_DRAIN_TIMEOUT_EN
          else if (to_cnt_q == 16'(TIMEOUT_CYC - 1)) begin
            out_start_d = 1'b0;
            err_d       = 1'b1;
            state_d     = DONE;
          end else begin
            to_cnt_d = to_cnt_q + 16'd1;
          end
`endif
        end
        DONE: begin
          is_finish_d = 1'b1;
          xfer_cnt_d  = xfer_cnt_q + 16'd1;
          state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      fifo_re_q    <= '0;
      out_data_q   <= '0;
      out_chan_q   <= '0;
      out_start_q  <= 1'b0;
      is_finish_q  <= 1'b0;
      xfer_cnt_q   <= '0;
      last_grant_q <= CW'(CH - 1);
    end else begin
      state_q      <= state_d;
      fifo_re_q    <= fifo_re_d;
      out_data_q   <= out_data_d;
      out_chan_q   <= out_chan_d;
      out_start_q  <= out_start_d;
      is_finish_q  <= is_finish_d;
      xfer_cnt_q   <= xfer_cnt_d;
      last_grant_q <= last_grant_d;
    end
  end

`ifdef FIFO_DRAIN_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end
`else
  logic unused_err_d;
  assign unused_err_d = err_d;
`endif

  assign fifo_re   = fifo_re_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_start = out_start_q;
  assign isFinish  = is_finish_q;
  assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_fifo_drain_arb.sv
// tb/tb_fifo_drain_arb.sv - randomized scoreboard bench for fifo_drain_arb
module tb_fifo_drain_arb;
  localparam int DATA_W = 8;
  localparam int CH     = 4;
  localparam int TO     = 8;

  logic                clk = 1'b0;
  logic                reset;
  logic                enable;
  logic [CH-1:0]       fifo_busy;
  logic [CH-1:0]       fifo_empty;
  logic [CH*DATA_W-1:0] fifo_data;
  logic [CH-1:0]       fifo_re;
  logic [DATA_W-1:0]   out_data;
  logic [1:0]          out_chan;
  logic                out_start;
  logic                out_finish;
  logic                isFinish;
  logic [15:0]         xfer_cnt;
  logic                err;

  fifo_drain_arb #(.DATA_W(DATA_W), .CH(CH), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .fifo_busy(fifo_busy), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_re(fifo_re), .out_data(out_data), .out_chan(out_chan),
    .out_start(out_start), .out_finish(out_finish), .isFinish(isFinish),
    .xfer_cnt(xfer_cnt), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               ch;
    logic [DATA_W-1:0] d;
    logic [15:0]      cnt;
    logic             err;
  } exp_t;

  exp_t        exp_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          lg_m;
  int          cnt_m;
  logic        err_m;
  int          grants_m = 0;
  int          re_pulses = 0;
  logic [DATA_W-1:0] word_m [CH];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic logic cond(input int what);
    case (what)
      0:       return fifo_re != '0;
      1:       return out_start == 1'b1;
      2:       return out_start == 1'b0;
      default: return isFinish == 1'b1;
    endcase
  endfunction

  task automatic wait_for(input int what, input string nm);
    int n = 0;
    while (!cond(what) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(nm, {31'd0, cond(what)}, 32'd1);
  endtask

  task automatic set_flags(input logic [CH-1:0] rdy, input int word);
    int r;
    for (int i = 0; i < CH; i++) begin
      if (rdy[i]) begin
        fifo_busy[i]  = 1'b0;
        fifo_empty[i] = 1'b0;
      end else begin
        r = int'($urandom_range(1, 3));
        fifo_busy[i]  = r[0];
        fifo_empty[i] = r[1];
      end
      word_m[i] = (word >= 0) ? DATA_W'(word) : DATA_W'($urandom);
      fifo_data[i*DATA_W +: DATA_W] = word_m[i];
    end
  endtask

  // Reference arbiter: nearest ready channel after the previous winner, modulo CH.
  function automatic int pick(input logic [CH-1:0] rdy);
    for (int k = 1; k <= CH; k++)
      if (rdy[(lg_m + k) % CH]) return (lg_m + k) % CH;
    return -1;
  endfunction

  task automatic xfer(input logic [CH-1:0] rdy, input int fin_dly, input int en_gap,
                      input bit exp_to, input int word);
    exp_t e;
    set_flags(rdy, word);
    e.ch  = pick(rdy);
    lg_m  = e.ch;
    e.d   = word_m[e.ch];
    cnt_m = (cnt_m + 1) % 65536;
    e.cnt = 16'(cnt_m);
    if (exp_to) err_m = 1'b1;
    e.err = err_m;
    grants_m++;
    exp_q.push_back(e);
    wait_for(0, "wait_grant");
    set_flags(CH'($urandom), -1);
    wait_for(1, "wait_start");
    if (exp_to) begin
      repeat (TO - 1) @(negedge clk);
      chk("start_held_before_timeout", {31'd0, out_start}, 32'd1);
      @(negedge clk);
      chk("start_dropped_at_timeout", {31'd0, out_start}, 32'd0);
    end else begin
      repeat (fin_dly) @(negedge clk);
      chk("start_held_until_finish", {31'd0, out_start}, 32'd1);
      out_finish = 1'b1;
      if (en_gap > 0) begin
        enable = 1'b0;
        repeat (en_gap) begin
          @(negedge clk);
          chk("start_held_while_disabled", {31'd0, out_start}, 32'd1);
        end
        enable = 1'b1;
      end
      wait_for(2, "wait_start_drop");
      out_finish = 1'b0;
    end
    wait_for(3, "wait_finish");
    set_flags('0, -1);
  endtask

  // Monitor: pops the scoreboard on every read strobe and checks completions.
  int   cyc = 0;
  int   grant_cyc = 0;
  bit   have_cur = 0;
  exp_t cur;
  logic prev_re_any = 1'b0, prev_start = 1'b0, prev_fin = 1'b0;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (reset) begin
      have_cur    = 0;
      prev_re_any = 1'b0;
      prev_start  = 1'b0;
      prev_fin    = 1'b0;
    end else begin
      if (fifo_re != '0) begin
        re_pulses++;
        chk("re_not_back_to_back", {31'd0, prev_re_any}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_grant", {28'd0, fifo_re}, 32'd0);
        end else begin
          cur       = exp_q.pop_front();
          have_cur  = 1;
          grant_cyc = cyc;
          chk("grant_re", {28'd0, fifo_re}, 32'd1 << cur.ch);
          chk("out_data", {24'd0, out_data}, {24'd0, cur.d});
          chk("out_chan", {30'd0, out_chan}, 32'(cur.ch));
        end
      end
      if (out_start && !prev_start && have_cur)
        chk("start_latency", 32'(cyc - grant_cyc), 32'd1);
      if (isFinish && !prev_fin) begin
        if (!have_cur) begin
          chk("unexpected_finish", {31'd0, isFinish}, 32'd0);
        end else begin
          chk("xfer_cnt", {16'd0, xfer_cnt}, {16'd0, cur.cnt});
          chk("err", {31'd0, err}, {31'd0, cur.err});
          chk("start_low_at_finish", {31'd0, out_start}, 32'd0);
          have_cur = 0;
        end
      end
      prev_re_any = (fifo_re != '0);
      prev_start  = out_start;
      prev_fin    = isFinish;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b1; out_finish = 1'b0;
    fifo_busy = '1; fifo_empty = '0; fifo_data = '0;
    lg_m = CH - 1; cnt_m = 0; err_m = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_fifo_re", {28'd0, fifo_re}, 32'd0);
    chk("reset_out_start", {31'd0, out_start}, 32'd0);
    chk("reset_isFinish", {31'd0, isFinish}, 32'd0);
    chk("reset_xfer_cnt", {16'd0, xfer_cnt}, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    chk("reset_out_data", {24'd0, out_data}, 32'd0);
    chk("reset_out_chan", {30'd0, out_chan}, 32'd0);
    reset = 1'b0;
    set_flags('0, -1);
    repeat (6) @(negedge clk);
    chk("idle_no_strobe", {28'd0, fifo_re}, 32'd0);

    xfer(4'b0100, 3, 0, 0, 8'hA5);
    for (int i = 0; i < 8; i++) xfer(4'hF, int'($urandom_range(0, 2)), 0, 0, -1);
    for (int i = 0; i < 30; i++)
      xfer(CH'($urandom_range(1, (1 << CH) - 1)), int'($urandom_range(0, 4)), 0, 0, -1);
    xfer(4'hF, 1, 5, 0, -1);
`ifndef FIFO_DRAIN_TIMEOUT_EN
    xfer(4'b1010, 20, 0, 0, -1);
`endif

    set_flags(4'hF, -1);
    lg_m = pick(4'hF);
    grants_m++;
    exp_q.push_back('{ch: lg_m, d: word_m[lg_m], cnt: 16'(cnt_m + 1), err: err_m});
    wait_for(0, "abort_wait_grant");
    set_flags('0, -1);
    wait_for(1, "abort_wait_start");
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_out_start", {31'd0, out_start}, 32'd0);
    chk("abort_isFinish", {31'd0, isFinish}, 32'd0);
    chk("abort_xfer_cnt", {16'd0, xfer_cnt}, 32'd0);
    chk("abort_fifo_re", {28'd0, fifo_re}, 32'd0);
    exp_q.delete();
    lg_m = CH - 1; cnt_m = 0; err_m = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    xfer(4'hF, 2, 0, 0, -1);
    xfer(CH'($urandom_range(1, (1 << CH) - 1)), 1, 0, 0, -1);

    force dut.xfer_cnt_q = 16'hFFFF;
    #1;
    release dut.xfer_cnt_q;
    cnt_m = 65535;
    xfer(4'hF, 1, 0, 0, -1);
    xfer(4'b0011, 0, 0, 0, -1);

`ifdef FIFO_DRAIN_TIMEOUT_EN
    xfer(4'hF, TO - 1, 0, 0, -1);
    xfer(4'hF, 0, 0, 1, -1);
    xfer(4'b0110, 2, 0, 0, -1);
`endif

    repeat (5) @(negedge clk);
    chk("pending_expectations", 32'(exp_q.size()), 32'd0);
    chk("re_pulse_count", 32'(re_pulses), 32'(grants_m));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
